product_accumulator: RTL and testbench

//  Downstream stage of the 4-bit array multiplier. Consumes its 8-bit products via a valid/ready

---
 rtl/product_accumulator.sv | 93 +++++++++
 tb/tb_product_accumulator.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums a burst of N_TERMS multiplier products (saturating) and holds the result on a valid/ready port.
// acc_valid rises 1 cycle after the last accept; prod_ready is 0 outside ACCUM, the result is held until acc_ready.
module product_accumulator #(
    parameter int PROD_W  = 8,
    parameter int ACC_W   = 12,
    parameter int N_TERMS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              sat,
    output logic [7:0]        term_cnt
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [7:0] LAST_TERM = 8'(N_TERMS - 1);

    state_t           state;
    logic             accept;
    logic [ACC_W:0]   sum_ext;

    assign accept  = prod_valid & prod_ready;
    // One extra bit catches the carry that signals saturation.
    assign sum_ext = {1'b0, acc_out} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc_out    <= '0;
            term_cnt   <= '0;
            sat        <= 1'b0;
            prod_ready <= 1'b0;
            acc_valid  <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            acc_out    <= '0;
            term_cnt   <= '0;
            sat        <= 1'b0;
            prod_ready <= 1'b0;
            acc_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACCUM;
                        acc_out    <= '0;
                        term_cnt   <= '0;
                        sat        <= 1'b0;
                        prod_ready <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        term_cnt <= term_cnt + 8'd1;
                        if (!sat) begin
                            if (sum_ext[ACC_W]) begin
                                acc_out <= '1;
                                sat     <= 1'b1;
                            end else begin
                                acc_out <= sum_ext[ACC_W-1:0];
                            end
                        end
                        if (term_cnt == LAST_TERM) begin
                            state      <= DONE;
                            prod_ready <= 1'b0;
                            acc_valid  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (acc_ready) begin
                        state     <= IDLE;
                        acc_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    prod_ready <= 1'b0;
                    acc_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: table of bursts on a 12-bit/16-term instance, saturation on a 10-bit/8-term instance,
// plus hand sequences for abort, asynchronous reset and start/acc_ready collision.
module tb_product_accumulator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_start, a_abort, a_prod_valid, a_prod_ready, a_acc_valid, a_acc_ready, a_sat;
    logic [7:0]  a_prod_in, a_term_cnt;
    logic [11:0] a_acc_out;

    logic        b_start, b_abort, b_prod_valid, b_prod_ready, b_acc_valid, b_acc_ready, b_sat;
    logic [7:0]  b_prod_in, b_term_cnt;
    logic [9:0]  b_acc_out;

    product_accumulator #(.PROD_W(8), .ACC_W(12), .N_TERMS(16)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .prod_in(a_prod_in), .prod_valid(a_prod_valid), .prod_ready(a_prod_ready),
        .acc_out(a_acc_out), .acc_valid(a_acc_valid), .acc_ready(a_acc_ready),
        .sat(a_sat), .term_cnt(a_term_cnt)
    );

    product_accumulator #(.PROD_W(8), .ACC_W(10), .N_TERMS(8)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .prod_in(b_prod_in), .prod_valid(b_prod_valid), .prod_ready(b_prod_ready),
        .acc_out(b_acc_out), .acc_valid(b_acc_valid), .acc_ready(b_acc_ready),
        .sat(b_sat), .term_cnt(b_term_cnt)
    );

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  step;
        bit          gaps;
        logic [11:0] exp_acc;
        bit          exp_sat;
    } vec_t;

    vec_t vecs[6];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // product k of a burst is base + step*k (mod 256)
        vecs[0] = '{base: 8'd225, step: 8'd0,  gaps: 1'b0, exp_acc: 12'd3600, exp_sat: 1'b0};
        vecs[1] = '{base: 8'd1,   step: 8'd1,  gaps: 1'b1, exp_acc: 12'd136,  exp_sat: 1'b0};
        vecs[2] = '{base: 8'd255, step: 8'd0,  gaps: 1'b0, exp_acc: 12'd4080, exp_sat: 1'b0};
        vecs[3] = '{base: 8'd0,   step: 8'd0,  gaps: 1'b1, exp_acc: 12'd0,    exp_sat: 1'b0};
        vecs[4] = '{base: 8'd0,   step: 8'd17, gaps: 1'b0, exp_acc: 12'd2040, exp_sat: 1'b0};
        vecs[5] = '{base: 8'd240, step: 8'd1,  gaps: 1'b1, exp_acc: 12'd3960, exp_sat: 1'b0};

        rst = 1'b1;
        a_start = 0; a_abort = 0; a_prod_in = 0; a_prod_valid = 0; a_acc_ready = 0;
        b_start = 0; b_abort = 0; b_prod_in = 0; b_prod_valid = 0; b_acc_ready = 0;
        #12;
        chk("rst_acc_out",   a_acc_out,    0);
        chk("rst_term_cnt",  a_term_cnt,   0);
        chk("rst_sat",       a_sat,        0);
        chk("rst_prod_rdy",  a_prod_ready, 0);
        chk("rst_acc_valid", a_acc_valid,  0);
        rst = 1'b0;
        step();
        chk("idle_prod_rdy", a_prod_ready, 0);

        for (int i = 0; i < 6; i++) begin
            a_start = 1; step(); a_start = 0;
            chk("burst_prod_rdy", a_prod_ready, 1);
            chk("burst_clr_acc",  a_acc_out,    0);
            for (int k = 0; k < 16; k++) begin
                if (vecs[i].gaps) begin
                    int g;
                    g = $urandom_range(0, 2);
                    for (int j = 0; j < g; j++) begin
                        a_prod_valid = 0; a_prod_in = 8'hFF;
                        step();
                        chk("gap_term_cnt", a_term_cnt, k);
                    end
                end
                a_prod_in    = 8'(vecs[i].base + vecs[i].step * k);
                a_prod_valid = 1;
                chk("pre_acc_valid", a_acc_valid, 0);
                chk("pre_prod_rdy",  a_prod_ready, 1);
                step();
            end
            a_prod_valid = 0;
            chk("done_acc_valid", a_acc_valid,  1);
            chk("done_acc_out",   a_acc_out,    vecs[i].exp_acc);
            chk("done_sat",       a_sat,        vecs[i].exp_sat);
            chk("done_term_cnt",  a_term_cnt,   16);
            chk("done_prod_rdy",  a_prod_ready, 0);
            // products offered while waiting on acc_ready must be ignored
            a_prod_valid = 1; a_prod_in = 8'd55;
            for (int h = 0; h < 5; h++) begin
                step();
                chk("hold_acc_valid", a_acc_valid, 1);
                chk("hold_acc_out",   a_acc_out,   vecs[i].exp_acc);
            end
            a_prod_valid = 0;
            a_acc_ready = 1; a_start = 1;
            step();
            a_acc_ready = 0; a_start = 0;
            chk("rel_acc_valid", a_acc_valid,  0);
            chk("rel_prod_rdy",  a_prod_ready, 0);
            chk("rel_acc_kept",  a_acc_out,    vecs[i].exp_acc);
            step();
            chk("rel_start_ign", a_prod_ready, 0);
        end

        // saturation on the 10-bit instance: 225 x 8
        begin
            int  sum;
            bit  s;
            sum = 0; s = 0;
            b_start = 1; step(); b_start = 0;
            for (int k = 0; k < 8; k++) begin
                b_prod_in = 8'd225; b_prod_valid = 1;
                step();
                sum = sum + 225;
                if (sum > 1023) s = 1;
                chk("b_acc_out",  b_acc_out,  s ? 1023 : sum);
                chk("b_sat",      b_sat,      s);
                chk("b_term_cnt", b_term_cnt, k + 1);
            end
            b_prod_valid = 0;
            chk("b_acc_valid", b_acc_valid, 1);
            b_acc_ready = 1; step(); b_acc_ready = 0;
            chk("b_rel_valid", b_acc_valid, 0);
            chk("b_rel_sat",   b_sat,       1);
        end

        // abort after 7 accepts, with a product on offer
        a_start = 1; step(); a_start = 0;
        for (int k = 0; k < 7; k++) begin
            a_prod_in = 8'd10; a_prod_valid = 1; step();
        end
        chk("abort_pre_cnt", a_term_cnt, 7);
        chk("abort_pre_acc", a_acc_out,  70);
        a_abort = 1;
        step();
        a_abort = 0; a_prod_valid = 0;
        chk("abort_prod_rdy", a_prod_ready, 0);
        chk("abort_acc_out",  a_acc_out,    0);
        chk("abort_term_cnt", a_term_cnt,   0);
        chk("abort_sat",      a_sat,        0);
        step();
        chk("abort_idle",     a_prod_ready, 0);

        // asynchronous reset between edges mid-burst
        a_start = 1; step(); a_start = 0;
        for (int k = 0; k < 3; k++) begin
            a_prod_in = 8'd50; a_prod_valid = 1; step();
        end
        a_prod_valid = 0;
        chk("rst_pre_acc", a_acc_out, 150);
        #2 rst = 1'b1;
        #1;
        chk("arst_acc_out",  a_acc_out,    0);
        chk("arst_term_cnt", a_term_cnt,   0);
        chk("arst_prod_rdy", a_prod_ready, 0);
        a_start = 1; a_prod_valid = 1; a_prod_in = 8'd99;
        step();
        a_start = 0; a_prod_valid = 0;
        rst = 1'b0;
        step();
        chk("arst_idle",     a_prod_ready, 0);
        chk("arst_acc_kept", a_acc_out,    0);
        chk("arst_valid",    a_acc_valid,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
